// File: rtl/sprite_port_arbiter.sv
// sprite_port_arbiter
// Shares port A of sprite_storage between the SPI write path and two read
// requesters (rd0 = scanline renderer, rd1 = collision/preview reader).
// Grants are combinational; at most one access is granted per cycle. Writes
// have priority, but a reader that has waited through STARVE_MAX write grants
// wins the next cycle. Readers are served round-robin. Each read returns one
// nibble with a one-cycle valid pulse READ_LATENCY+1 cycles after its grant.
// Optional build macro: ARB_STATS_EN adds saturating write/read/stall counters
// with a synchronous clear input.
module sprite_port_arbiter #(
    parameter int SEL_W        = 4,
    parameter int ADDR_W       = 13,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_MAX   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [SEL_W-1:0]  wr_select,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_gnt,
    input  logic              rd0_req,
    input  logic [SEL_W-1:0]  rd0_select,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_valid,
    output logic [3:0]        rd0_data,
    input  logic              rd1_req,
    input  logic [SEL_W-1:0]  rd1_select,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_valid,
    output logic [3:0]        rd1_data,
    output logic              st_w_en,
    output logic [SEL_W-1:0]  st_w_select,
    output logic [ADDR_W-1:0] st_w_addr,
    output logic [7:0]        st_w_data,
    output logic [SEL_W-1:0]  st_r0_select,
    output logic [ADDR_W-1:0] st_r0_addr,
    input  logic [3:0]        st_r0_data
`ifdef ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              any_rd_s;
    logic              wr_gnt_s;
    logic              rd0_gnt_s;
    logic              rd1_gnt_s;
    logic              rd_gnt_any_s;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_d;
    logic              rr_ptr_q;     // 0 = rd0 has precedence, 1 = rd1
    logic              rr_ptr_d;
    logic [SEL_W-1:0]  r_sel_q;
    logic [SEL_W-1:0]  r_sel_d;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] r_addr_d;
    // Tag pipe: one {valid, id} slot per cycle of storage read latency.
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_id_q;
    logic              pipe_out_vld_s;
    logic              pipe_out_id_s;
    logic              rd0_valid_q;
    logic              rd1_valid_q;
    logic [3:0]        rd0_data_q;
    logic [3:0]        rd1_data_q;

    assign any_rd_s       = rd0_req | rd1_req;
    assign rd_gnt_any_s   = rd0_gnt_s | rd1_gnt_s;
    assign pipe_out_vld_s = pipe_vld_q[READ_LATENCY-1];
    assign pipe_out_id_s  = pipe_id_q[READ_LATENCY-1];

    // Arbitration: write first unless a reader has been starved, then round-robin readers.
    always_comb begin
        wr_gnt_s  = 1'b0;
        rd0_gnt_s = 1'b0;
        rd1_gnt_s = 1'b0;
        if (wr_req && (!any_rd_s || (starve_cnt_q < STARVE_LIM))) begin
            wr_gnt_s = 1'b1;
        end else if (any_rd_s) begin
            if (rr_ptr_q == 1'b0) begin
                if (rd0_req) begin
                    rd0_gnt_s = 1'b1;
                end else begin
                    rd1_gnt_s = 1'b1;
                end
            end else begin
                if (rd1_req) begin
                    rd1_gnt_s = 1'b1;
                end else begin
                    rd0_gnt_s = 1'b1;
                end
            end
        end else begin
            wr_gnt_s = 1'b0;
        end
    end

    // Next-state for starvation counter, round-robin pointer and held read address.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        r_sel_d      = r_sel_q;
        r_addr_d     = r_addr_q;
        if (rd_gnt_any_s || !any_rd_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (wr_gnt_s && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        // The pointer moves to the reader that was not just served.
        if (rd0_gnt_s) begin
            rr_ptr_d = 1'b1;
            r_sel_d  = rd0_select;
            r_addr_d = rd0_addr;
        end else if (rd1_gnt_s) begin
            rr_ptr_d = 1'b0;
            r_sel_d  = rd1_select;
            r_addr_d = rd1_addr;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Arbiter state, tag pipe and registered read-return outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= {CNT_W{1'b0}};
            rr_ptr_q     <= 1'b0;
            r_sel_q      <= {SEL_W{1'b0}};
            r_addr_q     <= {ADDR_W{1'b0}};
            pipe_vld_q   <= {READ_LATENCY{1'b0}};
            pipe_id_q    <= {READ_LATENCY{1'b0}};
            rd0_valid_q  <= 1'b0;
            rd1_valid_q  <= 1'b0;
            rd0_data_q   <= 4'h0;
            rd1_data_q   <= 4'h0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            r_sel_q       <= r_sel_d;
            r_addr_q      <= r_addr_d;
            pipe_vld_q[0] <= rd_gnt_any_s;
            pipe_id_q[0]  <= rd1_gnt_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
            rd0_valid_q <= pipe_out_vld_s & ~pipe_out_id_s;
            rd1_valid_q <= pipe_out_vld_s & pipe_out_id_s;
            if (pipe_out_vld_s && !pipe_out_id_s) begin
                rd0_data_q <= st_r0_data;
            end
            if (pipe_out_vld_s && pipe_out_id_s) begin
                rd1_data_q <= st_r0_data;
            end
        end
    end

    assign wr_gnt       = wr_gnt_s;
    assign rd0_gnt      = rd0_gnt_s;
    assign rd1_gnt      = rd1_gnt_s;
    assign rd0_valid    = rd0_valid_q;
    assign rd1_valid    = rd1_valid_q;
    assign rd0_data     = rd0_data_q;
    assign rd1_data     = rd1_data_q;
    assign st_w_en      = wr_gnt_s;
    assign st_w_select  = wr_select;
    assign st_w_addr    = wr_addr;
    assign st_w_data    = wr_data;
    // Present the granted reader's address in its grant cycle, else hold the last one.
    assign st_r0_select = r_sel_d;
    assign st_r0_addr   = r_addr_d;

`ifdef ARB_STATS_EN
    logic [15:0] stat_wr_q;
    logic [15:0] stat_rd_q;
    logic [15:0] stat_stall_q;
    logic        stall_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    assign stall_s = (wr_req & ~wr_gnt_s) | (rd0_req & ~rd0_gnt_s) | (rd1_req & ~rd1_gnt_s);

    // Saturating activity counters, cleared by reset or stat_clr.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_wr_q    <= 16'h0000;
            stat_rd_q    <= 16'h0000;
            stat_stall_q <= 16'h0000;
        end else if (stat_clr) begin
            stat_wr_q    <= 16'h0000;
            stat_rd_q    <= 16'h0000;
            stat_stall_q <= 16'h0000;
        end else begin
            if (wr_gnt_s) begin
                stat_wr_q <= sat_inc(stat_wr_q);
            end
            if (rd_gnt_any_s) begin
                stat_rd_q <= sat_inc(stat_rd_q);
            end
            if (stall_s) begin
                stat_stall_q <= sat_inc(stat_stall_q);
            end
        end
    end

    assign stat_wr_cnt    = stat_wr_q;
    assign stat_rd_cnt    = stat_rd_q;
    assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_sprite_port_arbiter.sv
// Testbench for sprite_port_arbiter: directed request vectors with hand-computed
// grant sequences, a behavioural sprite_storage model, and a scoreboard queue
// of expected read returns that a negedge monitor pops on every valid pulse.
module tb_sprite_port_arbiter;

    localparam int SEL_W  = 4;
    localparam int ADDR_W = 13;
    localparam int LAT    = 1;
    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_WR   = 3'b100;
    localparam logic [2:0] G_R0   = 3'b010;
    localparam logic [2:0] G_R1   = 3'b001;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic wr_req = 1'b0, rd0_req = 1'b0, rd1_req = 1'b0;
    logic [SEL_W-1:0]  wr_select = '0, rd0_select = '0, rd1_select = '0;
    logic [ADDR_W-1:0] wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
    logic [7:0]        wr_data = '0;
    logic wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, st_w_en;
    logic [3:0] rd0_data, rd1_data;
    logic [SEL_W-1:0]  st_w_select, st_r0_select;
    logic [ADDR_W-1:0] st_w_addr, st_r0_addr;
    logic [7:0] st_w_data;
    logic [3:0] st_r0_data = 4'h0;
`ifdef ARB_STATS_EN
    logic stat_clr = 1'b0;
    logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
    logic chk_stats = 1'b0;
    logic [15:0] exp_wr = 16'd0, exp_rd = 16'd0, exp_stall = 16'd0;
`endif

    // Staging values copied onto the DUT inputs just after a rising edge.
    logic [SEL_W-1:0]  n_ws = '0, n_s0 = '0, n_s1 = '0;
    logic [ADDR_W-1:0] n_wa = '0, n_a0 = '0, n_a1 = '0;
    logic [7:0]        n_wd = '0;

    logic [2:0] exp_gnt    = G_NONE;
    logic       gnt_chk_en = 1'b0;
    logic       chk_rst    = 1'b0;
    logic       chk_end    = 1'b0;
    int         cyc        = 0;
    int         n_chk      = 0;
    int         n_err      = 0;

    typedef struct {
        logic       id;
        logic [3:0] data;
        int         due;
    } ret_t;
    ret_t rdq[$];

    logic [3:0] mem [int];

    sprite_port_arbiter #(.SEL_W(SEL_W), .ADDR_W(ADDR_W), .READ_LATENCY(LAT), .STARVE_MAX(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_req(wr_req), .wr_select(wr_select), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd0_req(rd0_req), .rd0_select(rd0_select), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
        .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_select(rd1_select), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
        .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .st_w_en(st_w_en), .st_w_select(st_w_select), .st_w_addr(st_w_addr), .st_w_data(st_w_data),
        .st_r0_select(st_r0_select), .st_r0_addr(st_r0_addr), .st_r0_data(st_r0_data)
`ifdef ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Storage content: written nibbles, else a fixed pattern of sel and addr.
    function automatic logic [3:0] mem_rd(input logic [SEL_W-1:0] sel, input logic [ADDR_W-1:0] addr);
        int k;
        k = int'({sel, addr});
        if (mem.exists(k)) return mem[k];
        return 4'((int'(sel) * 3 + int'(addr[3:0]) + int'(addr[7:4])) & 15);
    endfunction

    // Behavioural port A: one-cycle registered read, byte write into two nibbles.
    always @(posedge clock) begin
        int k;
        st_r0_data <= mem_rd(st_r0_select, st_r0_addr);
        if (st_w_en) begin
            k = int'({st_w_select, st_w_addr});
            mem[k]     = st_w_data[3:0];
            mem[k + 1] = st_w_data[7:4];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: check grants and returns, push expected read returns on each grant.
    always @(negedge clock) begin
        ret_t e;
        if (chk_rst)
            chk("reset_outputs", 32'({wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, st_w_en,
                                      rd0_data, rd1_data}), 32'd0);
        if (!reset_n) begin
            rdq.delete();
        end else begin
            if (rdq.size() > 0 && rdq[0].due < cyc) begin
                chk("valid_missing", 32'(cyc), 32'(rdq[0].due));
                void'(rdq.pop_front());
            end
            if (rd0_valid || rd1_valid) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_valid", 32'({rd1_valid, rd0_valid}), 32'd0);
                end else begin
                    e = rdq.pop_front();
                    chk("valid_id", 32'({rd1_valid, rd0_valid}), e.id ? 32'd2 : 32'd1);
                    chk("rd_data", 32'(e.id ? rd1_data : rd0_data), 32'(e.data));
                    chk("valid_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (gnt_chk_en)
                chk("grant", 32'({wr_gnt, rd0_gnt, rd1_gnt}), 32'(exp_gnt));
            if (wr_gnt)
                chk("st_w_pass", 32'({st_w_en, st_w_select, st_w_addr, st_w_data}),
                    32'({1'b1, wr_select, wr_addr, wr_data}));
            if (rd0_gnt) begin
                chk("st_r0_mux", 32'({st_r0_select, st_r0_addr}), 32'({rd0_select, rd0_addr}));
                rdq.push_back('{1'b0, mem_rd(rd0_select, rd0_addr), cyc + LAT + 1});
            end
            if (rd1_gnt) begin
                chk("st_r0_mux", 32'({st_r0_select, st_r0_addr}), 32'({rd1_select, rd1_addr}));
                rdq.push_back('{1'b1, mem_rd(rd1_select, rd1_addr), cyc + LAT + 1});
            end
`ifdef ARB_STATS_EN
            if (chk_stats) begin
                chk("stat_wr", 32'(stat_wr_cnt), 32'(exp_wr));
                chk("stat_rd", 32'(stat_rd_cnt), 32'(exp_rd));
                chk("stat_stall", 32'(stat_stall_cnt), 32'(exp_stall));
            end
`endif
        end
        if (chk_end)
            chk("pending_reads", 32'(rdq.size()), 32'd0);
    end

    task automatic drive(input logic w, input logic r0, input logic r1, input logic [2:0] g);
        @(posedge clock);
        #1;
        wr_req = w;   rd0_req = r0;  rd1_req = r1;
        wr_select = n_ws; wr_addr = n_wa; wr_data = n_wd;
        rd0_select = n_s0; rd0_addr = n_a0;
        rd1_select = n_s1; rd1_addr = n_a1;
        exp_gnt = g;
        gnt_chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, G_NONE);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 chk_rst = 1'b1;
        @(posedge clock);
        #1 chk_rst = 1'b0;
        reset_n = 1'b1;

        // Single rd0 read: sel 3, addr 0x010 (pattern nibble 0xA)
        n_s0 = 4'd3; n_a0 = 13'h010;
        drive(1'b0, 1'b1, 1'b0, G_R0);
        idle(3);
        // Single rd1 read, returns pointer to rd0
        n_s1 = 4'd5; n_a1 = 13'h011;
        drive(1'b0, 1'b0, 1'b1, G_R1);
        idle(3);

        // Both readers held: strict alternation starting at rd0
        n_s0 = 4'd4; n_s1 = 4'd6;
        for (int i = 0; i < 6; i++) begin
            n_a0 = 13'(32'h030 + i); n_a1 = 13'(32'h050 + i);
            drive(1'b0, 1'b1, 1'b1, (i % 2 == 1) ? G_R1 : G_R0);
        end
        idle(4);

        // Write held with rd0 waiting: 8 writes, 1 read, repeating
        n_s0 = 4'd1; n_a0 = 13'h040; n_ws = 4'd7;
        for (int i = 0; i < 20; i++) begin
            n_wa = 13'(32'h100 + 2 * i); n_wd = 8'(i * 17);
            drive(1'b1, 1'b1, 1'b0, (i % 9 == 8) ? G_R0 : G_WR);
        end
        idle(4);

        // Write 0xA5 to sel 2 addr 0x020, then read back both nibbles
        n_ws = 4'd2; n_wa = 13'h020; n_wd = 8'hA5;
        drive(1'b1, 1'b0, 1'b0, G_WR);
        n_s0 = 4'd2; n_a0 = 13'h020;
        drive(1'b0, 1'b1, 1'b0, G_R0);
        n_a0 = 13'h021;
        drive(1'b0, 1'b1, 1'b0, G_R0);
        idle(3);

        // All three at once: write wins; dropped requests are not served
        n_ws = 4'd9; n_wa = 13'h200; n_wd = 8'h3C; n_s1 = 4'd8; n_a1 = 13'h0F0;
        drive(1'b1, 1'b1, 1'b1, G_WR);
        idle(1);
        // Write alone is granted every cycle
        for (int i = 0; i < 3; i++) begin
            n_wa = 13'(32'h210 + 2 * i);
            drive(1'b1, 1'b0, 1'b0, G_WR);
        end
        idle(1);
        // Starvation limit with rd1 waiting
        for (int i = 0; i < 10; i++) begin
            n_wa = 13'(32'h300 + 2 * i); n_a1 = 13'(32'h0A0 + i);
            drive(1'b1, 1'b0, 1'b1, (i == 8) ? G_R1 : G_WR);
        end
        idle(3);

        // Three reads in flight, then a one-cycle reset pulse
        n_s0 = 4'd11;
        for (int i = 0; i < 3; i++) begin
            n_a0 = 13'(32'h060 + i);
            drive(1'b0, 1'b1, 1'b0, G_R0);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b0; wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
        gnt_chk_en = 1'b0; chk_rst = 1'b1;
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);
        chk_rst = 1'b0;
        idle(3);

`ifdef ARB_STATS_EN
        // 4 writes, 2 reads, 3 blocked cycles
        n_ws = 4'd1; n_wa = 13'h400; n_s0 = 4'd2; n_a0 = 13'h044;
        drive(1'b1, 1'b0, 1'b0, G_WR);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, G_WR);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, G_R0);
        idle(1);
        exp_wr = 16'd4; exp_rd = 16'd2; exp_stall = 16'd3; chk_stats = 1'b1;
        idle(1);
        chk_stats = 1'b0; stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        exp_wr = 16'd0; exp_rd = 16'd0; exp_stall = 16'd0; chk_stats = 1'b1;
        idle(1);
        chk_stats = 1'b0;
        idle(2);
`endif

        idle(3);
        chk_end = 1'b1;
        @(negedge clock);
        #1 chk_end = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
